// File: rtl/share_bus_codec_pkg.sv
// Shared constants and index helpers for the share-major / shbus encodings.
package share_bus_codec_pkg;

  localparam int unsigned D_DEFAULT     = 2;
  localparam int unsigned COUNT_DEFAULT = 128;
  localparam int unsigned WIDTH_DEFAULT = 8;

  // Position of bit j of share i in the bit-interleaved shbus vector.
  function automatic int unsigned shbus_idx(int unsigned i, int unsigned j, int unsigned d);
    return j * d + i;
  endfunction

  // Position of bit j of share i in the share-major vector.
  function automatic int unsigned share_idx(int unsigned i, int unsigned j, int unsigned count);
    return i * count + j;
  endfunction

endpackage

// File: rtl/share_bus_codec_word_order_swap.sv
// Reverses the order of WIDTH-bit words in a BSIZE-bit vector; bits inside a word keep their order.
module word_order_swap
  import share_bus_codec_pkg::*;
#(
  parameter int unsigned BSIZE = COUNT_DEFAULT,
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [BSIZE-1:0] data_in,
  output logic [BSIZE-1:0] data_out
);

  localparam int unsigned N = BSIZE / WIDTH;

  if (BSIZE % WIDTH != 0) begin : g_bad_bsize
    $error("word_order_swap: BSIZE must be a multiple of WIDTH");
  end

  for (genvar k = 0; k < N; k++) begin : g_word
    assign data_out[k*WIDTH +: WIDTH] = data_in[(N-1-k)*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/share_bus_codec.sv
// Registered share-major <-> shbus codec with XOR recombination and word-order reversal.
// Data registers load only when in_valid is high; out_valid follows in_valid every cycle.
module share_bus_codec
  import share_bus_codec_pkg::*;
#(
  parameter int unsigned D     = D_DEFAULT,
  parameter int unsigned COUNT = COUNT_DEFAULT,
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [D*COUNT-1:0] shares_in,
  input  logic [D*COUNT-1:0] shbus_in,
  output logic               out_valid,
  output logic [D*COUNT-1:0] shbus_out,
  output logic [D*COUNT-1:0] shares_out,
  output logic [COUNT-1:0]   recombined,
  output logic [COUNT-1:0]   recombined_rev
);

  if (D == 0) begin : g_bad_d
    $error("share_bus_codec: D must be at least 1");
  end
  if (COUNT % WIDTH != 0) begin : g_bad_count
    $error("share_bus_codec: COUNT must be a multiple of WIDTH");
  end

  logic [D*COUNT-1:0] shbus_enc;
  logic [D*COUNT-1:0] shares_dec;
  logic [COUNT-1:0]   rec_c;
  logic [COUNT-1:0]   rev_c;

  logic               out_valid_d,      out_valid_q;
  logic [D*COUNT-1:0] shbus_out_d,      shbus_out_q;
  logic [D*COUNT-1:0] shares_out_d,     shares_out_q;
  logic [COUNT-1:0]   recombined_d,     recombined_q;
  logic [COUNT-1:0]   recombined_rev_d, recombined_rev_q;

  for (genvar i = 0; i < D; i++) begin : g_share
    for (genvar j = 0; j < COUNT; j++) begin : g_bit
      assign shbus_enc[shbus_idx(i, j, D)]      = shares_in[share_idx(i, j, COUNT)];
      assign shares_dec[share_idx(i, j, COUNT)] = shbus_in[shbus_idx(i, j, D)];
    end
  end

  // Recombination folds the already-decoded shares, so it shares wiring with shares_out.
  always_comb begin
    rec_c = '0;
    for (int unsigned i = 0; i < D; i++) begin
      rec_c = rec_c ^ shares_dec[i*COUNT +: COUNT];
    end
  end

  word_order_swap #(
    .BSIZE(COUNT),
    .WIDTH(WIDTH)
  ) u_word_order_swap (
    .data_in (rec_c),
    .data_out(rev_c)
  );

  always_comb begin
    out_valid_d      = in_valid;
    shbus_out_d      = shbus_out_q;
    shares_out_d     = shares_out_q;
    recombined_d     = recombined_q;
    recombined_rev_d = recombined_rev_q;
    if (in_valid) begin
      shbus_out_d      = shbus_enc;
      shares_out_d     = shares_dec;
      recombined_d     = rec_c;
      recombined_rev_d = rev_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q      <= 1'b0;
      shbus_out_q      <= '0;
      shares_out_q     <= '0;
      recombined_q     <= '0;
      recombined_rev_q <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      shbus_out_q      <= shbus_out_d;
      shares_out_q     <= shares_out_d;
      recombined_q     <= recombined_d;
      recombined_rev_q <= recombined_rev_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign shbus_out      = shbus_out_q;
  assign shares_out     = shares_out_q;
  assign recombined     = recombined_q;
  assign recombined_rev = recombined_rev_q;

endmodule

// File: tb/tb_share_bus_codec.sv
// Scoreboard bench for share_bus_codec across four parameter sets (D=2/128, D=2/8, D=3/16, D=1/32).
module tb_share_bus_codec;

  localparam int unsigned NI = 4;
  localparam int unsigned W  = 8;

  typedef logic [383:0] vec_t;
  typedef logic [127:0] word_t;
  typedef struct packed {
    logic  valid;
    vec_t  shbus;
    vec_t  shares;
    word_t rec;
    word_t rev;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: D=2 COUNT=128
  logic         def_iv;  logic [255:0] def_sin, def_bin, def_bout, def_sout;
  logic         def_ov;  logic [127:0] def_rec, def_rev;
  // instance 1: D=2 COUNT=8
  logic         sml_iv;  logic [15:0]  sml_sin, sml_bin, sml_bout, sml_sout;
  logic         sml_ov;  logic [7:0]   sml_rec, sml_rev;
  // instance 2: D=3 COUNT=16
  logic         d3_iv;   logic [47:0]  d3_sin, d3_bin, d3_bout, d3_sout;
  logic         d3_ov;   logic [15:0]  d3_rec, d3_rev;
  // instance 3: D=1 COUNT=32
  logic         d1_iv;   logic [31:0]  d1_sin, d1_bin, d1_bout, d1_sout;
  logic         d1_ov;   logic [31:0]  d1_rec, d1_rev;

  share_bus_codec #(.D(2), .COUNT(128), .WIDTH(8)) u_def (
    .clk(clk), .rst(rst), .in_valid(def_iv), .shares_in(def_sin), .shbus_in(def_bin),
    .out_valid(def_ov), .shbus_out(def_bout), .shares_out(def_sout),
    .recombined(def_rec), .recombined_rev(def_rev));
  share_bus_codec #(.D(2), .COUNT(8), .WIDTH(8)) u_sml (
    .clk(clk), .rst(rst), .in_valid(sml_iv), .shares_in(sml_sin), .shbus_in(sml_bin),
    .out_valid(sml_ov), .shbus_out(sml_bout), .shares_out(sml_sout),
    .recombined(sml_rec), .recombined_rev(sml_rev));
  share_bus_codec #(.D(3), .COUNT(16), .WIDTH(8)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(d3_iv), .shares_in(d3_sin), .shbus_in(d3_bin),
    .out_valid(d3_ov), .shbus_out(d3_bout), .shares_out(d3_sout),
    .recombined(d3_rec), .recombined_rev(d3_rev));
  share_bus_codec #(.D(1), .COUNT(32), .WIDTH(8)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(d1_iv), .shares_in(d1_sin), .shbus_in(d1_bin),
    .out_valid(d1_ov), .shbus_out(d1_bout), .shares_out(d1_sout),
    .recombined(d1_rec), .recombined_rev(d1_rev));

  int   vectors    = 0;
  int   miscompares = 0;
  exp_t sb [NI][$];
  exp_t last [NI];

  function automatic int unsigned p_d(int unsigned k);
    case (k)
      0, 1:    return 2;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned p_c(int unsigned k);
    case (k)
      0:       return 128;
      1:       return 8;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic exp_t model(int unsigned k, vec_t sh, vec_t bus);
    exp_t e;
    int unsigned d = p_d(k);
    int unsigned c = p_c(k);
    int unsigned n = c / W;
    e = '0;
    e.valid = 1'b1;
    for (int unsigned i = 0; i < d; i++) begin
      for (int unsigned j = 0; j < c; j++) begin
        e.shbus[j*d+i]  = sh[i*c+j];
        e.shares[i*c+j] = bus[j*d+i];
        e.rec[j]        = e.rec[j] ^ bus[j*d+i];
      end
    end
    for (int unsigned kk = 0; kk < n; kk++) begin
      for (int unsigned b = 0; b < W; b++) begin
        e.rev[kk*W+b] = e.rec[(n-1-kk)*W+b];
      end
    end
    return e;
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    for (int w = 0; w < 12; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic exp_t obs(int unsigned k);
    exp_t o;
    o = '0;
    case (k)
      0: begin o.valid = def_ov; o.shbus[255:0] = def_bout; o.shares[255:0] = def_sout;
               o.rec[127:0] = def_rec; o.rev[127:0] = def_rev; end
      1: begin o.valid = sml_ov; o.shbus[15:0] = sml_bout; o.shares[15:0] = sml_sout;
               o.rec[7:0] = sml_rec; o.rev[7:0] = sml_rev; end
      2: begin o.valid = d3_ov; o.shbus[47:0] = d3_bout; o.shares[47:0] = d3_sout;
               o.rec[15:0] = d3_rec; o.rev[15:0] = d3_rev; end
      default: begin o.valid = d1_ov; o.shbus[31:0] = d1_bout; o.shares[31:0] = d1_sout;
               o.rec[31:0] = d1_rec; o.rev[31:0] = d1_rev; end
    endcase
    return o;
  endfunction

  task automatic set_in(input int unsigned k, input logic v, input vec_t sh, input vec_t bus);
    case (k)
      0:       begin def_iv = v; def_sin = sh[255:0]; def_bin = bus[255:0]; end
      1:       begin sml_iv = v; sml_sin = sh[15:0];  sml_bin = bus[15:0];  end
      2:       begin d3_iv  = v; d3_sin  = sh[47:0];  d3_bin  = bus[47:0];  end
      default: begin d1_iv  = v; d1_sin  = sh[31:0];  d1_bin  = bus[31:0];  end
    endcase
  endtask

  task automatic drive_const(input int unsigned k, input vec_t sh, input vec_t bus, input exp_t e);
    set_in(k, 1'b1, sh, bus);
    last[k] = e;
    sb[k].push_back(e);
  endtask

  task automatic drive(input int unsigned k, input logic v, input vec_t sh, input vec_t bus);
    set_in(k, v, sh, bus);
    if (v) last[k] = model(k, sh, bus);
    else   last[k].valid = 1'b0;
    sb[k].push_back(last[k]);
  endtask

  task automatic idle_all();
    for (int unsigned k = 0; k < NI; k++) begin
      set_in(k, 1'b0, rnd(), rnd());
      last[k].valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    exp_t o;
    for (int unsigned k = 0; k < NI; k++) set_in(k, 1'b0, '0, '0);
    #1 rst = 1'b0;
    #12;
    for (int unsigned k = 0; k < NI; k++) begin
      o = obs(k);
      vectors++;
      if (o !== '0) begin
        miscompares++;
        $display("FAIL reset_state inst%0d: got valid=%b rec=%h shbus=%h, required all zero",
                 k, o.valid, o.rec, o.shbus);
      end
      last[k] = '0;
    end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_small_vector();
    exp_t e, o;
    vec_t sh, bus;
    sh = '0;  sh[15:0]  = 16'hA53C;
    bus = '0; bus[15:0] = 16'h8D72;
    e = '0;
    e.valid = 1'b1;
    e.shbus[15:0]  = 16'h8D72;
    e.shares[15:0] = 16'hA53C;
    e.rec[7:0]     = 8'h99;
    e.rev[7:0]     = 8'h99;
    drive_const(1, sh, bus, e);
    @(posedge clk); #1;
    e = sb[1].pop_front(); o = obs(1);
    vectors++;
    if (o.shbus !== e.shbus) begin miscompares++;
      $display("FAIL small_vector shbus_out: got %h required %h", o.shbus[15:0], e.shbus[15:0]); end
    vectors++;
    if (o.shares !== e.shares) begin miscompares++;
      $display("FAIL small_vector shares_out: got %h required %h", o.shares[15:0], e.shares[15:0]); end
    vectors++;
    if ({o.valid, o.rec, o.rev} !== {e.valid, e.rec, e.rev}) begin miscompares++;
      $display("FAIL small_vector valid/rec/rev: got %b/%h/%h required %b/%h/%h",
               o.valid, o.rec[7:0], o.rev[7:0], e.valid, e.rec[7:0], e.rev[7:0]); end
    idle_all();
  endtask

  task automatic test_endian();
    exp_t e, o;
    vec_t sh, bus;
    sh = '0; sh[127:0] = 128'hffeeddccbbaa99887766554433221100;
    bus = model(0, sh, '0).shbus;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        drive(0, 1'b1, sh, '0);
      end else begin
        e = '0;
        e.valid = 1'b1;
        e.shbus = bus;
        e.shares[127:0] = 128'hffeeddccbbaa99887766554433221100;
        e.rec = 128'hffeeddccbbaa99887766554433221100;
        e.rev = 128'h00112233445566778899aabbccddeeff;
        drive_const(0, sh, bus, e);
      end
      @(posedge clk); #1;
      e = sb[0].pop_front(); o = obs(0);
      vectors++;
      if (o.shbus !== e.shbus) begin miscompares++;
        $display("FAIL endian_c%0d shbus_out: got %h required %h", c, o.shbus[255:0], e.shbus[255:0]); end
      vectors++;
      if (o.shares !== e.shares) begin miscompares++;
        $display("FAIL endian_c%0d shares_out: got %h required %h", c, o.shares[255:0], e.shares[255:0]); end
      vectors++;
      if ({o.valid, o.rec, o.rev} !== {e.valid, e.rec, e.rev}) begin miscompares++;
        $display("FAIL endian_c%0d valid/rec/rev: got %b/%h/%h required %b/%h/%h",
                 c, o.valid, o.rec, o.rev, e.valid, e.rec, e.rev); end
    end
    idle_all();
  endtask

  task automatic test_three_shares();
    exp_t e, o;
    vec_t sh, bus;
    sh = '0; sh[47:0] = 48'h00F0_FFFF_1234;
    bus = model(2, sh, '0).shbus;
    e = '0;
    e.valid = 1'b1;
    e.shbus = bus;
    e.shares[47:0] = 48'h00F0_FFFF_1234;
    e.rec[15:0] = 16'hED3B;
    e.rev[15:0] = 16'h3BED;
    drive_const(2, sh, bus, e);
    @(posedge clk); #1;
    e = sb[2].pop_front(); o = obs(2);
    vectors++;
    if (o.shbus !== e.shbus) begin miscompares++;
      $display("FAIL three_shares shbus_out: got %h required %h", o.shbus[47:0], e.shbus[47:0]); end
    vectors++;
    if (o.shares !== e.shares) begin miscompares++;
      $display("FAIL three_shares shares_out: got %h required %h", o.shares[47:0], e.shares[47:0]); end
    vectors++;
    if ({o.valid, o.rec, o.rev} !== {e.valid, e.rec, e.rev}) begin miscompares++;
      $display("FAIL three_shares valid/rec/rev: got %b/%h/%h required %b/%h/%h",
               o.valid, o.rec[15:0], o.rev[15:0], e.valid, e.rec[15:0], e.rev[15:0]); end
    idle_all();
  endtask

  // mode 0: back-to-back random traffic; mode 1: one valid beat then five held cycles
  task automatic test_stream(input int mode, input int cycles);
    exp_t e, o;
    logic v;
    for (int c = 0; c < cycles; c++) begin
      for (int unsigned k = 0; k < NI; k++) begin
        if (mode == 0) v = ($urandom_range(0, 3) != 0);
        else           v = (c == 0);
        drive(k, v, rnd(), rnd());
      end
      @(posedge clk); #1;
      for (int unsigned k = 0; k < NI; k++) begin
        e = sb[k].pop_front(); o = obs(k);
        vectors++;
        if (o.shbus !== e.shbus) begin miscompares++;
          $display("FAIL stream%0d_c%0d_i%0d shbus_out: got %h required %h", mode, c, k, o.shbus, e.shbus); end
        vectors++;
        if (o.shares !== e.shares) begin miscompares++;
          $display("FAIL stream%0d_c%0d_i%0d shares_out: got %h required %h", mode, c, k, o.shares, e.shares); end
        vectors++;
        if ({o.valid, o.rec, o.rev} !== {e.valid, e.rec, e.rev}) begin miscompares++;
          $display("FAIL stream%0d_c%0d_i%0d valid/rec/rev: got %b/%h/%h required %b/%h/%h",
                   mode, c, k, o.valid, o.rec, o.rev, e.valid, e.rec, e.rev); end
      end
    end
    idle_all();
  endtask

  task automatic test_reset_midstream();
    exp_t o;
    test_stream(0, 0);
    for (int unsigned k = 0; k < NI; k++) drive(k, 1'b1, rnd(), rnd());
    @(posedge clk); #1;
    for (int unsigned k = 0; k < NI; k++) begin
      o = obs(k);
      vectors++;
      if (o.valid !== 1'b1) begin miscompares++;
        $display("FAIL pre_reset_valid inst%0d: got %b required 1", k, o.valid); end
      void'(sb[k].pop_front());
    end
    #2 rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      #1;
      for (int unsigned k = 0; k < NI; k++) begin
        o = obs(k);
        vectors++;
        if (o !== '0) begin miscompares++;
          $display("FAIL midstream_reset_r%0d inst%0d: got valid=%b rec=%h shbus=%h, required all zero",
                   r, k, o.valid, o.rec, o.shbus); end
        last[k] = '0;
        set_in(k, 1'b1, rnd(), rnd());
      end
      if (r == 0) @(posedge clk);
    end
    @(negedge clk) rst = 1'b1;
    test_stream(0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_small_vector();
    test_endian();
    test_three_shares();
    test_stream(0, 24);
    test_stream(1, 6);
    test_reset_midstream();
    test_stream(0, 8);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/share_bus_codec.md
Name: share_bus_codec

Overview:
- Registered utility block for masked datapaths.
- Converts share-major vectors into the bit-interleaved "shbus" encoding used by the masked cores, and converts shbus back to share-major form.
- Recombines shares by XOR to recover the unmasked value, and returns that value with its WIDTH-bit words in reversed order for comparison against byte-ordered reference data.
- Sits at the boundary between test/host logic and masked cores such as the AES core.

Parameters:
- D, 2, number of shares (≥1).
- COUNT, 128, bits per share; must be a multiple of WIDTH.
- WIDTH, 8, word size used for the endian reversal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies shares_in and shbus_in this cycle.
- shares_in  in  D*COUNT  share-major input; share i is bits [i*COUNT +: COUNT].
- shbus_in  in  D*COUNT  bit-interleaved input; bit j of share i is bit [j*D+i].
- out_valid  out  1  registered copy of in_valid.
- shbus_out  out  D*COUNT  shbus encoding of shares_in.
- shares_out  out  D*COUNT  share-major decoding of shbus_in.
- recombined  out  COUNT  XOR of all D shares of the decoded shbus_in.
- recombined_rev  out  COUNT  recombined with word order reversed.

Behaviour:
- Encode: shbus_out[j*D+i] = shares_in[i*COUNT+j], for 0≤i<D and 0≤j<COUNT.
- Decode is the exact inverse: shares_out[i*COUNT+j] = shbus_in[j*D+i].
- Recombine: recombined[j] = XOR over i of shbus_in[j*D+i].
  - For D=1, recombined equals the single share.
- Reverse: with N = COUNT/WIDTH, recombined_rev[k*WIDTH +: WIDTH] = recombined[(N-1-k)*WIDTH +: WIDTH].
  - Bit order inside each word is preserved.
  - For N=1 this is the identity.
- Latency: all outputs are registered exactly one cycle after sampling.
  - Data registers load only when in_valid=1.
  - When in_valid=0 they hold their previous value.
  - out_valid <= in_valid every cycle.
- No backpressure: the block accepts a new input every cycle, giving a throughput of 1 per clock.
- Reset: asserting rst low immediately (asynchronously) clears every output to 0, including out_valid.
  - Reset is also honoured mid-stream; any in-flight value is discarded.
  - On the first rising edge after rst deasserts, normal sampling resumes.
- The data path combinational to each register is pure wiring or XOR. There are no arithmetic carries and no width truncation.
- Elaboration error if COUNT % WIDTH != 0 or D < 1.

Decomposition:
- Shared package holds:
  - Encoding index helpers: shbus_idx(i,j,D) = j*D+i and share_idx(i,j,COUNT) = i*COUNT+j.
  - Default constants D=2, COUNT=128, WIDTH=8.
- One natural combinational sub-module, word_order_swap (parameters BSIZE, WIDTH), instantiated for recombined_rev.
- The encoder, decoder and XOR tree stay inline as generate loops.

Test Plan:
- D=2, COUNT=8, WIDTH=8; shares_in=16'hA53C with in_valid=1 -> next cycle shbus_out=16'h8D72 and out_valid=1.
- D=2, COUNT=8, WIDTH=8; shbus_in=16'h8D72 -> shares_out=16'hA53C, recombined=8'h99, recombined_rev=8'h99.
- D=2, COUNT=128 (defaults); share0=128'hffeeddccbbaa99887766554433221100, share1=0, fed through encode then decode -> recombined=ffeeddccbbaa99887766554433221100 and recombined_rev=00112233445566778899aabbccddeeff.
- D=3, COUNT=16, WIDTH=8; decoded shares 16'h1234, 16'hFFFF, 16'h00F0 -> recombined=16'hED3B, recombined_rev=16'h3BED.
- Hold: in_valid=0 for 5 cycles with changing inputs -> outputs unchanged and out_valid=0 from the cycle after in_valid drops.
- Reset: drive rst low between clock edges while out_valid=1 -> all outputs 0 immediately; first valid input after release appears one cycle later.
